point_stream_loader: RTL and testbench

- Writer side of the point memory consumed by the max-area solver.
- Accepts the puzzle input as an ASCII byte stream of lines "X,Y\n" with unsigned decimal fields.
- Parses each line into a 64-bit word {X[31:0] in [63:32], Y[31:0] in [31:0]} and writes it to sequential RAM addresses starting at 0.
- Reports the final point count so the solver no longer depends on a preloaded hex file and a compile-time NUM_POINTS.

---
 rtl/point_stream_loader_if.sv | 27 ++
 rtl/point_stream_loader.sv | 164 ++++++++++++++++
 tb/tb_point_stream_loader.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/point_stream_loader_if.sv
// Byte-stream input and point-RAM write bundle for point_stream_loader.
// The master side supplies ASCII bytes; the slave side (the loader) drives the
// RAM write port and the status outputs.
interface point_stream_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
  logic [ADDR_W:0]   num_points;
  logic              done;
  logic              error;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data, num_points, done, error
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data, num_points, done, error
  );
endinterface

// File: rtl/point_stream_loader.sv
// Parses an ASCII stream of "X,Y\n" lines into 64-bit {X,Y} words and writes
// them to consecutive point-RAM addresses starting at 0. Reports the number of
// committed points plus sticky done/error flags.
module point_stream_loader #(
  parameter int MAX_POINTS = 1024,
  parameter int ADDR_W     = 10
) (
  input logic                clk,
  input logic                rst,
  point_stream_loader_if.slave bus
);

  typedef enum logic [1:0] {S_X, S_Y, S_DONE, S_ERR} state_t;

  state_t            state;
  logic [31:0]       acc;
  logic [31:0]       x_val;
  logic              has_digit;
  logic              in_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [63:0]       wr_data_q;
  logic [ADDR_W:0]   num_points_q;
  logic              done_q;
  logic              error_q;

  logic              accept;
  logic              is_digit, is_comma, is_cr, is_lf;
  logic [35:0]       acc_mul;
  logic              acc_ovf;
  state_t            st_byte, st_next;
  logic [31:0]       acc_byte, x_byte, y_commit;
  logic              hd_byte, err_byte, commit_lf;
  logic              commit_last, err_last, commit, cap_full;

  assign accept = bus.in_valid && in_ready_q;

  // Byte decode, then the effect of the byte alone, then the in_last overlay.
  always_comb begin
    is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
    is_comma = (bus.in_data == 8'h2c);
    is_cr    = (bus.in_data == 8'h0d);
    is_lf    = (bus.in_data == 8'h0a);
    acc_mul  = {4'b0, acc} * 36'd10 + {32'b0, bus.in_data[3:0]};
    acc_ovf  = |acc_mul[35:32];

    st_byte   = state;
    acc_byte  = acc;
    x_byte    = x_val;
    hd_byte   = has_digit;
    err_byte  = 1'b0;
    commit_lf = 1'b0;

    case (state)
      S_X: begin
        if (is_digit) begin
          if (acc_ovf) begin
            err_byte = 1'b1;
          end else begin
            acc_byte = acc_mul[31:0];
            hd_byte  = 1'b1;
          end
        end else if (is_comma) begin
          if (has_digit) begin
            x_byte   = acc;
            acc_byte = '0;
            hd_byte  = 1'b0;
            st_byte  = S_Y;
          end else begin
            err_byte = 1'b1;
          end
        end else if (is_lf) begin
          // A newline with no X digits is a blank line and is skipped.
          err_byte = has_digit;
        end else if (!is_cr) begin
          err_byte = 1'b1;
        end
      end
      S_Y: begin
        if (is_digit) begin
          if (acc_ovf) begin
            err_byte = 1'b1;
          end else begin
            acc_byte = acc_mul[31:0];
            hd_byte  = 1'b1;
          end
        end else if (is_lf) begin
          if (has_digit) begin
            commit_lf = 1'b1;
            acc_byte  = '0;
            hd_byte   = 1'b0;
            st_byte   = S_X;
          end else begin
            err_byte = 1'b1;
          end
        end else if (!is_cr) begin
          err_byte = 1'b1;
        end
      end
      default: ;
    endcase

    // On a newline commit the accumulator is about to be cleared, so Y is the
    // pre-byte value; on an in_last commit it is the post-byte value.
    y_commit    = commit_lf ? acc : acc_byte;
    commit_last = bus.in_last && !err_byte && (st_byte == S_Y) && hd_byte;
    err_last    = bus.in_last && !err_byte &&
                  ((st_byte == S_Y) ? !hd_byte : hd_byte);
    commit      = commit_lf || commit_last;
    cap_full    = (num_points_q == (ADDR_W+1)'(MAX_POINTS));

    if (err_byte || err_last || (commit && cap_full))
      st_next = S_ERR;
    else if (bus.in_last)
      st_next = S_DONE;
    else
      st_next = st_byte;
  end

  // Parser state, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_X;
      acc          <= '0;
      x_val        <= '0;
      has_digit    <= 1'b0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      num_points_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (accept) begin
        state      <= st_next;
        acc        <= acc_byte;
        x_val      <= x_byte;
        has_digit  <= hd_byte;
        in_ready_q <= (st_next == S_X) || (st_next == S_Y);
        done_q     <= (st_next == S_DONE) || (st_next == S_ERR);
        error_q    <= (st_next == S_ERR);
        if (commit && !cap_full) begin
          wr_en_q      <= 1'b1;
          wr_addr_q    <= num_points_q[ADDR_W-1:0];
          wr_data_q    <= {x_byte, y_commit};
          num_points_q <= num_points_q + 1'b1;
        end
      end else begin
        in_ready_q <= (state == S_X) || (state == S_Y);
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.num_points = num_points_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_point_stream_loader.sv
// Bench for point_stream_loader: directed streams plus random streams scored
// against a line-oriented reference parser.
module tb_point_stream_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       drv_valid = 1'b0;
  logic       drv_last = 1'b0;
  logic [7:0] drv_data = 8'h00;
  bit         sel = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  point_stream_loader_if #(.ADDR_W(10)) if0 ();
  point_stream_loader_if #(.ADDR_W(10)) if1 ();

  assign if0.in_valid = drv_valid && !sel;
  assign if0.in_data  = drv_data;
  assign if0.in_last  = drv_last;
  assign if1.in_valid = drv_valid && sel;
  assign if1.in_data  = drv_data;
  assign if1.in_last  = drv_last;

  point_stream_loader #(.MAX_POINTS(1024), .ADDR_W(10)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  point_stream_loader #(.MAX_POINTS(2), .ADDR_W(10)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  logic        m_rdy, m_wr_en, m_done, m_err;
  logic [9:0]  m_addr;
  logic [63:0] m_data;
  logic [10:0] m_num;
  assign m_rdy   = sel ? if1.in_ready   : if0.in_ready;
  assign m_wr_en = sel ? if1.wr_en      : if0.wr_en;
  assign m_addr  = sel ? if1.wr_addr    : if0.wr_addr;
  assign m_data  = sel ? if1.wr_data    : if0.wr_data;
  assign m_num   = sel ? if1.num_points : if0.num_points;
  assign m_done  = sel ? if1.done       : if0.done;
  assign m_err   = sel ? if1.error      : if0.error;

  // Observed writes, and a count of writes not preceded by a terminating byte.
  logic [9:0]  obs_a[$];
  logic [63:0] obs_d[$];
  int          lat_bad = 0;
  bit          prev_commit = 1'b0;

  always @(negedge clk) begin
    if (m_wr_en) begin
      obs_a.push_back(m_addr);
      obs_d.push_back(m_data);
      if (!prev_commit) lat_bad <= lat_bad + 1;
    end
    prev_commit <= drv_valid && m_rdy && (drv_data == 8'h0a || drv_last);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [63:0] exp_w[$];
  bit          exp_done, exp_err;

  function automatic bit line_ok(input byte ln[$], output logic [63:0] v);
    int     comma = -1;
    int     ncomma = 0;
    longint x = 0, y = 0;
    bit     ok = 1'b1;
    v = '0;
    for (int i = 0; i < ln.size(); i++) begin
      if (ln[i] == 8'h2c) begin
        ncomma++;
        comma = i;
      end else if (ln[i] < 8'h30 || ln[i] > 8'h39) begin
        ok = 1'b0;
      end
    end
    if (ncomma != 1 || comma == 0 || comma == ln.size() - 1) ok = 1'b0;
    if (ok) begin
      for (int i = 0; i < comma; i++)
        if (x <= 64'hFFFFFFFF) x = x * 10 + longint'(ln[i] - 8'h30);
      for (int i = comma + 1; i < ln.size(); i++)
        if (y <= 64'hFFFFFFFF) y = y * 10 + longint'(ln[i] - 8'h30);
      if (x > 64'hFFFFFFFF || y > 64'hFFFFFFFF) ok = 1'b0;
      v = {x[31:0], y[31:0]};
    end
    return ok;
  endfunction

  // Split into lines (CR dropped), parse each whole line; a trailing partial
  // line only counts when the stream is closed by in_last.
  task automatic model(input string s, input bit last, input int maxp);
    byte         ln[$];
    logic [63:0] v;
    exp_w = {};
    exp_err = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      byte b = s[i];
      if (b == 8'h0a) begin
        if (ln.size() != 0) begin
          if (!line_ok(ln, v) || exp_w.size() == maxp) begin
            exp_err = 1'b1;
            break;
          end
          exp_w.push_back(v);
        end
        ln = {};
      end else if (b != 8'h0d) begin
        ln.push_back(b);
      end
    end
    if (!exp_err && last && ln.size() != 0) begin
      if (!line_ok(ln, v) || exp_w.size() == maxp) exp_err = 1'b1;
      else exp_w.push_back(v);
    end
    exp_done = exp_err || last;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    obs_a = {};
    obs_d = {};
    lat_bad = 0;
  endtask

  // Present bytes one per cycle with optional random idle gaps; stops early
  // once the loader stops accepting (terminal state).
  task automatic send(input string s, input bit last, input int gap_pct);
    int i = 0;
    int budget = s.len() * 20 + 50;
    while (i < s.len() && budget > 0) begin
      budget--;
      if ($urandom_range(99) < gap_pct) begin
        drv_valid = 1'b0;
        drv_last  = 1'b0;
      end else begin
        drv_valid = 1'b1;
        drv_data  = s[i];
        drv_last  = last && (i == s.len() - 1);
      end
      @(negedge clk);
      if (drv_valid) begin
        if (m_rdy) i++;
        else begin
          @(posedge clk); #1;
          break;
        end
      end
      @(posedge clk); #1;
    end
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    if (budget == 0) begin
      errors++;
      $display("FAIL send_timeout: sent %0d of %0d bytes", i, s.len());
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 1'b0;
    drv_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({m_rdy, m_wr_en, m_done, m_err} !== 4'b0000 || m_addr !== '0 ||
        m_data !== '0 || m_num !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b wr_en=%b done=%b err=%b addr=%h data=%h num=%0d, required all 0",
               m_rdy, m_wr_en, m_done, m_err, m_addr, m_data, m_num);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, required 1", m_rdy);
    end
  endtask

  task automatic test_basic();
    logic [63:0] exp[4] = '{64'h00000007_00000001, 64'h0000000B_00000001,
                            64'h0000000B_00000007, 64'h00000009_00000007};
    do_reset();
    send("7,1\n11,1\n11,7\n9,7\n", 1'b1, 0);
    settle();
    checks++;
    if (obs_d.size() !== 4) begin
      errors++;
      $display("FAIL basic_count: writes=%0d, required 4", obs_d.size());
    end
    for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
      checks++;
      if (obs_d[i] !== exp[i] || obs_a[i] !== 10'(i)) begin
        errors++;
        $display("FAIL basic_write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, obs_a[i], obs_d[i], i, exp[i]);
      end
    end
    checks++;
    if (m_num !== 11'd4 || m_done !== 1'b1 || m_err !== 1'b0 || lat_bad !== 0) begin
      errors++;
      $display("FAIL basic_status: num=%0d done=%b err=%b late=%0d, required 4 1 0 0",
               m_num, m_done, m_err, lat_bad);
    end
  endtask

  task automatic test_max_value();
    do_reset();
    send("4294967295,0", 1'b1, 0);
    settle();
    checks++;
    if (obs_d.size() !== 1 || obs_d[0] !== 64'hFFFFFFFF_00000000 || obs_a[0] !== 10'd0) begin
      errors++;
      $display("FAIL maxval_write: writes=%0d data=%h, required 1 ffffffff00000000",
               obs_d.size(), (obs_d.size() > 0) ? obs_d[0] : 64'h0);
    end
    checks++;
    if (m_num !== 11'd1 || m_done !== 1'b1 || m_err !== 1'b0 || lat_bad !== 0) begin
      errors++;
      $display("FAIL maxval_status: num=%0d done=%b err=%b late=%0d, required 1 1 0 0",
               m_num, m_done, m_err, lat_bad);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send("4294967296,1\n", 1'b0, 0);
    settle();
    checks++;
    if (obs_d.size() !== 0 || m_num !== 11'd0 || m_err !== 1'b1 || m_done !== 1'b1 ||
        m_rdy !== 1'b0) begin
      errors++;
      $display("FAIL overflow: writes=%0d num=%0d err=%b done=%b rdy=%b, required 0 0 1 1 0",
               obs_d.size(), m_num, m_err, m_done, m_rdy);
    end
  endtask

  task automatic test_cr_blank();
    do_reset();
    send("3,4\015\n\n5,,6\n", 1'b0, 0);
    settle();
    checks++;
    if (obs_d.size() !== 1 || obs_d[0] !== 64'h00000003_00000004) begin
      errors++;
      $display("FAIL crblank_write: writes=%0d data=%h, required 1 0000000300000004",
               obs_d.size(), (obs_d.size() > 0) ? obs_d[0] : 64'h0);
    end
    checks++;
    if (m_num !== 11'd1 || m_err !== 1'b1 || m_done !== 1'b1 || m_rdy !== 1'b0) begin
      errors++;
      $display("FAIL crblank_status: num=%0d err=%b done=%b rdy=%b, required 1 1 1 0",
               m_num, m_err, m_done, m_rdy);
    end
  endtask

  task automatic test_capacity();
    sel = 1'b1;
    do_reset();
    send("1,1\n2,2\n3,3\n", 1'b0, 0);
    settle();
    checks++;
    if (obs_d.size() !== 2 || obs_d[0] !== 64'h00000001_00000001 ||
        obs_d[1] !== 64'h00000002_00000002 || obs_a[1] !== 10'd1) begin
      errors++;
      $display("FAIL capacity_writes: writes=%0d, required 2 writes of 1,1 and 2,2", obs_d.size());
    end
    checks++;
    if (m_num !== 11'd2 || m_err !== 1'b1 || m_done !== 1'b1) begin
      errors++;
      $display("FAIL capacity_status: num=%0d err=%b done=%b, required 2 1 1",
               m_num, m_err, m_done);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_midline();
    do_reset();
    send("12,3", 1'b0, 0);
    settle();
    checks++;
    if (obs_d.size() !== 0 || m_num !== 11'd0 || m_done !== 1'b0) begin
      errors++;
      $display("FAIL midline_partial: writes=%0d num=%0d done=%b, required 0 0 0",
               obs_d.size(), m_num, m_done);
    end
    do_reset();
    send("5,6\n", 1'b1, 0);
    settle();
    checks++;
    if (obs_d.size() !== 1 || obs_d[0] !== 64'h00000005_00000006 ||
        m_num !== 11'd1 || m_done !== 1'b1 || m_err !== 1'b0) begin
      errors++;
      $display("FAIL midline_after: writes=%0d num=%0d done=%b err=%b, required 1 write 0000000500000006, 1 1 0",
               obs_d.size(), m_num, m_done, m_err);
    end
  endtask

  function automatic string rnd_num();
    logic [31:0] v;
    v = ($urandom_range(3) == 0) ? $urandom() : 32'($urandom_range(100000));
    return $sformatf("%0d", v);
  endfunction

  function automatic string gen_stream(output bit last);
    string s = "";
    int    nl = $urandom_range(1, 8);
    for (int k = 0; k < nl; k++) begin
      int r = $urandom_range(99);
      if (r < 8) s = {s, "\n"};
      else if (r < 14) begin
        case ($urandom_range(3))
          0: s = {s, "1,2,3\n"};
          1: s = {s, ",5\n"};
          2: s = {s, "77\n"};
          default: s = {s, "99999999999,1\n"};
        endcase
      end else begin
        s = {s, rnd_num(), ",", rnd_num(), ($urandom_range(9) == 0) ? "\015\n" : "\n"};
      end
    end
    last = 1'($urandom_range(1));
    if ($urandom_range(2) == 0) begin
      s = {s, $sformatf("%0d", $urandom_range(999))};
      if ($urandom_range(1) == 1) s = {s, ",", $sformatf("%0d", $urandom_range(999))};
    end
    return s;
  endfunction

  task automatic test_random(input int iters);
    string s;
    bit    last;
    for (int it = 0; it < iters; it++) begin
      s = gen_stream(last);
      model(s, last, 1024);
      do_reset();
      send(s, last, (it % 2 == 1) ? 35 : 0);
      settle();
      checks++;
      if (obs_d.size() !== exp_w.size()) begin
        errors++;
        $display("FAIL rand%0d_count: writes=%0d, required %0d", it, obs_d.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < obs_d.size(); i++) begin
        checks++;
        if (obs_d[i] !== exp_w[i] || obs_a[i] !== 10'(i)) begin
          errors++;
          $display("FAIL rand%0d_write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                   it, i, obs_a[i], obs_d[i], i, exp_w[i]);
        end
      end
      checks++;
      if (m_num !== 11'(exp_w.size()) || m_done !== exp_done || m_err !== exp_err ||
          lat_bad !== 0) begin
        errors++;
        $display("FAIL rand%0d_status: num=%0d done=%b err=%b late=%0d, required %0d %b %b 0",
                 it, m_num, m_done, m_err, lat_bad, exp_w.size(), exp_done, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_value();
    test_overflow();
    test_cr_blank();
    test_capacity();
    test_reset_midline();
    test_random(30);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
